// File: rtl/md_pkg.sv
// Shared command codes, default latencies and result types
// for the execute-stage multiply/divide unit.
package md_pkg;

  localparam logic [5:0] CMD_MULT  = 6'h12;
  localparam logic [5:0] CMD_MULTU = 6'h13;
  localparam logic [5:0] CMD_DIV   = 6'h14;
  localparam logic [5:0] CMD_DIVU  = 6'h15;
  localparam logic [5:0] CMD_MFHI  = 6'h16;
  localparam logic [5:0] CMD_MFLO  = 6'h17;
  localparam logic [5:0] CMD_MTHI  = 6'h18;
  localparam logic [5:0] CMD_MTLO  = 6'h19;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } md_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } md_res_t;

  function automatic logic is_md(input logic [5:0] cmd);
    return (cmd >= CMD_MULT) && (cmd <= CMD_MTLO);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide with
// divide-by-zero detection.
module md_arith
  import md_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output md_res_t     res_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               sgn;
  logic        [31:0] abs_a;
  logic        [31:0] abs_b;
  logic        [31:0] dvsr;
  logic        [31:0] quo;
  logic        [31:0] rem;

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s = $signed({{32{a_i[31]}}, a_i})
           * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'h0, a_i} * {32'h0, b_i};
    sgn    = (op_i == OP_DIV);
    abs_a  = (sgn && a_i[31]) ? -a_i : a_i;
    abs_b  = (sgn && b_i[31]) ? -b_i : b_i;
    dvsr   = (b_i == 32'h0) ? 32'h1 : abs_b;
    quo    = abs_a / dvsr;
    rem    = abs_a % dvsr;
    if (sgn && (a_i[31] ^ b_i[31])) quo = -quo;
    if (sgn && a_i[31])             rem = -rem;
    res_o = '0;
    unique case (op_i)
      OP_MULT:  begin
        res_o.hi = prod_s[63:32];
        res_o.lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_o.hi = prod_u[63:32];
        res_o.lo = prod_u[31:0];
      end
      default:  begin
        res_o.hi   = rem;
        res_o.lo   = quo;
        res_o.div0 = (b_i == 32'h0);
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: HI/LO registers, busy counter
// and D-stage stall request.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  e_command,
  input  logic [5:0]  d_command,
  input  logic        flush,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] rd_data
);

  localparam int CW = 8;

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          div0_q, div0_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic    e_mul, e_div, e_mfhi, e_mflo;
  logic    e_mthi, e_mtlo;
  md_op_e  op;
  md_res_t res;

  always_comb begin
    e_mul  = (e_command == CMD_MULT)
           | (e_command == CMD_MULTU);
    e_div  = (e_command == CMD_DIV)
           | (e_command == CMD_DIVU);
    e_mfhi = (e_command == CMD_MFHI);
    e_mflo = (e_command == CMD_MFLO);
    e_mthi = (e_command == CMD_MTHI);
    e_mtlo = (e_command == CMD_MTLO);
    op     = md_op_e'(e_command[1:0] ^ 2'b10);
  end

  md_arith u_arith (
    .op_i  (op),
    .a_i   (src_a),
    .b_i   (src_b),
    .res_o (res)
  );

  assign start    = (e_mul | e_div) & ~busy_q & ~flush;
  assign busy     = busy_q;
  assign md_stall = (start | busy_q) & is_md(d_command);

  always_comb begin
    rd_data = 32'h0;
    unique case (1'b1)
      e_mfhi:  rd_data = hi_q;
      e_mflo:  rd_data = lo_q;
      default: rd_data = 32'h0;
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    div0_d = div0_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start) begin
      phi_d  = res.hi;
      plo_d  = res.lo;
      div0_d = res.div0;
      busy_d = 1'b1;
      cnt_d  = e_mul ? CW'(MULT_CYCLES)
                     : CW'(DIV_CYCLES);
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (!div0_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end
    end else if (!flush) begin
      if (e_mthi) hi_d = src_a;
      if (e_mtlo) lo_d = src_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      div0_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      div0_q <= div0_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed timeline cases
// plus randomized traffic against a cycle-indexed model.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  e_command, d_command;
  logic        flush;
  logic [31:0] src_a, src_b;
  logic        start, busy, md_stall;
  logic [31:0] rd_data;

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 0;

  md_unit dut (
    .clk       (clk),
    .reset     (reset),
    .e_command (e_command),
    .d_command (d_command),
    .flush     (flush),
    .src_a     (src_a),
    .src_b     (src_b),
    .start     (start),
    .busy      (busy),
    .md_stall  (md_stall),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // Model: architectural HI/LO plus the one outstanding op,
  // which lands at the edge closing cycle m_done.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pend, m_z;
  int          m_cur, m_done;

  function automatic bit is_op(input logic [5:0] c);
    return c inside {CMD_MULT, CMD_MULTU, CMD_DIV, CMD_DIVU};
  endfunction

  function automatic bit is_mdc(input logic [5:0] c);
    return c >= 6'h12 && c <= 6'h19;
  endfunction

  task automatic calc(input logic [5:0] c,
                      input logic [31:0] a, b,
                      output logic [31:0] h, l,
                      output bit z);
    longint sp, sq, sr;
    logic [63:0] up;
    z = 0;
    h = 0;
    l = 0;
    case (c)
      CMD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
        h = up[63:32];
        l = up[31:0];
      end
      CMD_MULTU: begin
        up = 64'(a) * 64'(b);
        h = up[63:32];
        l = up[31:0];
      end
      CMD_DIV: begin
        z = (b == 0);
        if (!z) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          up = sq;
          l = up[31:0];
          up = sr;
          h = up[31:0];
        end
      end
      default: begin
        z = (b == 0);
        if (!z) begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  function automatic logic exp_start();
    return is_op(e_command) && !m_pend && !flush;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
      m_pend = 0; m_z = 0;
    end else if (m_pend) begin
      if (m_cur == m_done) begin
        m_pend = 0;
        if (!m_z) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
      end
    end else if (exp_start()) begin
      calc(e_command, src_a, src_b, m_phi, m_plo, m_z);
      m_pend = 1;
      m_done = m_cur
             + ((e_command inside {CMD_MULT, CMD_MULTU}) ? 5 : 10);
    end else if (!flush) begin
      if (e_command == CMD_MTHI) m_hi = src_a;
      if (e_command == CMD_MTLO) m_lo = src_a;
    end
    m_cur++;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act, exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] er;
      er = (e_command == CMD_MFHI) ? m_hi
         : (e_command == CMD_MFLO) ? m_lo : 32'h0;
      chk("m_start", 32'(start), 32'(exp_start()));
      chk("m_busy",  32'(busy),  32'(m_pend));
      chk("m_stall", 32'(md_stall),
          32'((exp_start() || m_pend) && is_mdc(d_command)));
      chk("m_rd", rd_data, er);
    end
  end

  task automatic drive(input logic [5:0] e, d,
                       input logic f,
                       input logic [31:0] a, b);
    e_command = e;
    d_command = d;
    flush = f;
    src_a = a;
    src_b = b;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_op(input logic [5:0] op, d,
                        input logic [31:0] a, b,
                        input int n,
                        input logic [31:0] eh, el);
    drive(op, d, 0, a, b);
    chk("start", 32'(start), 32'd1);
    chk("stall_t", 32'(md_stall), 32'(is_mdc(d)));
    tick();
    for (int i = 1; i <= n; i++) begin
      drive(6'h0, d, 0, 0, 0);
      chk("busy_run", 32'(busy), 32'd1);
      chk("stall_run", 32'(md_stall), 32'(is_mdc(d)));
      tick();
    end
    drive(CMD_MFHI, d, 0, 0, 0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("stall_end", 32'(md_stall), 32'd0);
    chk("hi", rd_data, eh);
    tick();
    drive(CMD_MFLO, 6'h0, 0, 0, 0);
    chk("lo", rd_data, el);
    tick();
  endtask

  initial begin
    m_cur = 0; m_pend = 0; m_done = 0;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_z = 0;
    reset = 1;
    e_command = 0; d_command = 0; flush = 0;
    src_a = 0; src_b = 0;
    tick();
    tick();
    reset = 0;
    chk_en = 1;

    drive(CMD_MFHI, 0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", rd_data, 32'h0);
    tick();

    run_op(CMD_MULT, CMD_MFLO, 32'hFFFFFFFE, 32'd3, 5,
           32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op(CMD_MULTU, CMD_MULT, 32'hFFFFFFFE, 32'd3, 5,
           32'h00000002, 32'hFFFFFFFA);
    run_op(CMD_DIV, 6'h0, 32'hFFFFFFF9, 32'd2, 10,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(CMD_DIVU, 6'h0, 32'hFFFFFFF9, 32'd2, 10,
           32'h00000001, 32'h7FFFFFFC);
    run_op(CMD_DIV, 6'h0, 32'h80000000, 32'hFFFFFFFF, 10,
           32'h00000000, 32'h80000000);

    drive(CMD_MTHI, 0, 0, 32'h1234, 0);
    tick();
    drive(CMD_MTLO, 0, 0, 32'h5678, 0);
    tick();
    run_op(CMD_DIV, 6'h0, 32'h99, 32'h0, 10,
           32'h1234, 32'h5678);

    drive(CMD_MULT, CMD_MFLO, 1, 32'd7, 32'd9);
    chk("flush_start", 32'(start), 32'd0);
    chk("flush_stall", 32'(md_stall), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("flush_busy", 32'(busy), 32'd0);
    tick();
    drive(CMD_MTHI, 0, 1, 32'hDEAD, 0);
    tick();
    drive(CMD_MFHI, 0, 0, 0, 0);
    chk("flush_mthi", rd_data, 32'h1234);
    tick();

    drive(CMD_DIV, 0, 0, 32'd100, 32'd7);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      tick();
    end
    drive(CMD_MFHI, 0, 0, 0, 0);
    chk("rst_mid_hi", rd_data, 32'h0);
    tick();
    drive(CMD_MFLO, 0, 0, 0, 0);
    chk("rst_mid_lo", rd_data, 32'h0);
    tick();

    for (int i = 0; i < 4000; i++) begin
      logic [5:0]  e, d;
      logic [31:0] a, b;
      logic        f;
      e = ($urandom_range(0, 9) < 7)
        ? 6'(6'h12 + $urandom_range(0, 7))
        : 6'($urandom_range(0, 63));
      d = ($urandom_range(0, 1) == 1)
        ? 6'(6'h12 + $urandom_range(0, 7))
        : 6'($urandom_range(0, 63));
      f = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        2: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if (m_pend && is_mdc(e) && !f) e = 6'h0;
      reset = ($urandom_range(0, 299) == 0);
      drive(e, d, f, a, b);
      tick();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
